// File: rtl/sp_ram_acc_pkg.sv
// Shared types and window-map helpers for the RAM wrapper and its accelerator controller.
// Bank offsets are byte offsets from the window base, one 4-byte word per bank entry.
package sp_ram_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } acc_state_e;

  typedef enum logic [2:0] {
    SEL_RAM  = 3'd0,
    SEL_A    = 3'd1,
    SEL_B    = 3'd2,
    SEL_RES  = 3'd3,
    SEL_CTRL = 3'd4,
    SEL_NONE = 3'd5
  } acc_sel_e;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_DONE_BIT  = 2;
  localparam int CTRL_ERR_BIT   = 3;

  function automatic int bank_a_off(input int depth);
    return 0 * depth;
  endfunction

  function automatic int bank_b_off(input int depth);
    return 4 * depth;
  endfunction

  function automatic int res_off(input int depth);
    return 8 * depth;
  endfunction

  function automatic int ctrl_off(input int depth);
    return 12 * depth;
  endfunction

  function automatic int win_bytes(input int depth);
    return 16 * depth;
  endfunction

endpackage

// File: rtl/sp_ram_acc_ctrl.sv
// Accelerator control FSM (IDLE/RUN/CAPT) with CTRL status: busy, sticky done, sticky err.
// Optional watchdog enabled by macro ACC_TIMEOUT_EN; start pulse appears in the first RUN cycle.
module sp_ram_acc_ctrl
  import sp_ram_acc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_i,
  input  logic start_wr_i,
  input  logic done_clr_i,
  input  logic err_clr_i,
  input  logic acc_done_i,
  output logic acc_start_o,
  output logic capt_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic irq_o
);

  acc_state_e state_q, state_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       timeout_hit;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = done_q;
    if (done_clr_i) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_wr_i) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (acc_done_i)       state_d = CAPT;
        else if (timeout_hit) state_d = IDLE;
      end
      CAPT: begin
        // Capture sets done after any same-cycle W1C so the completion is never lost.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign acc_start_o = start_q;
  assign capt_o      = (state_q == CAPT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

`ifdef ACC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == RUN) && !acc_done_i &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = (state_q == RUN) ? cnt_q + 1'b1 : '0;
    err_d = err_q;
    if (err_clr_i)   err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
  assign irq_o = done_q | err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  // No watchdog in this build: RUN waits for acc_done_i indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign err_o       = 1'b0;
  assign irq_o       = done_q;
`endif

endmodule

// File: rtl/sp_ram_acc_ram.sv
// Behavioural single-port RAM macro with per-byte write enables.
// One-cycle read latency; output register holds while the port is idle.
module sp_ram_acc_ram #(
  parameter int WORDS = 8192,
  parameter int AW    = 13,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [DW/8-1:0]   wea_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DW-1:0]     din_i,
  output logic [DW-1:0]     dout_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (wea_i[i]) mem_q[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
      end
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/sp_ram_acc_wrap.sv
// Data RAM wrapper with an accelerator window (banks A/B, result bank, CTRL); reads return 1 cycle later.
// No backpressure: every access completes; A/B writes are dropped while busy. Optional macro: ACC_TIMEOUT_EN.
module sp_ram_acc_wrap
  import sp_ram_acc_pkg::*;
#(
  parameter int RAM_SIZE       = 32768,
  parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH     = 32,
  parameter int ACC_BASE       = 'h7000,
  parameter int ACC_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic                            we_i,
  input  logic [DATA_WIDTH/8-1:0]         be_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [ACC_DEPTH*DATA_WIDTH-1:0] acc_a_o,
  output logic [ACC_DEPTH*DATA_WIDTH-1:0] acc_b_o,
  input  logic [ACC_DEPTH*DATA_WIDTH-1:0] acc_res_i,
  output logic                            acc_start_o,
  input  logic                            acc_done_i,
  output logic                            irq_o
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int BOFF_W    = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int RAM_WORDS = RAM_SIZE / BE_W;
  localparam int RAM_AW    = $clog2(RAM_WORDS);
  localparam int IDX_W     = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam int OFF_B     = bank_b_off(ACC_DEPTH);
  localparam int OFF_RES   = res_off(ACC_DEPTH);
  localparam int OFF_CTRL  = ctrl_off(ACC_DEPTH);
  localparam int WIN_BYTES = win_bytes(ACC_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(ACC_BASE);

  logic [ADDR_WIDTH-1:0] off;
  logic                  in_win;
  acc_sel_e              sel_dec;
  logic [IDX_W-1:0]      idx_dec;

  // Word index comes straight from the offset because each bank spans a power-of-two word count.
  always_comb begin
    off     = addr_i - BASE_A;
    in_win  = (addr_i >= BASE_A) && (off < ADDR_WIDTH'(WIN_BYTES));
    idx_dec = off[2 +: IDX_W];
    sel_dec = SEL_RAM;
    if (in_win) begin
      if (off < ADDR_WIDTH'(OFF_B))         sel_dec = SEL_A;
      else if (off < ADDR_WIDTH'(OFF_RES))  sel_dec = SEL_B;
      else if (off < ADDR_WIDTH'(OFF_CTRL)) sel_dec = SEL_RES;
      else if (idx_dec == '0)               sel_dec = SEL_CTRL;
      else                                  sel_dec = SEL_NONE;
    end
  end

  logic ctrl_wr, busy, capt, done, err;
  logic start_wr, done_clr, err_clr;

  assign ctrl_wr  = en_i & we_i & (sel_dec == SEL_CTRL) & be_i[0];
  assign start_wr = ctrl_wr & wdata_i[CTRL_START_BIT];
  assign done_clr = ctrl_wr & wdata_i[CTRL_DONE_BIT];
  assign err_clr  = ctrl_wr & wdata_i[CTRL_ERR_BIT];

  sp_ram_acc_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_wr_i  (start_wr),
    .done_clr_i  (done_clr),
    .err_clr_i   (err_clr),
    .acc_done_i  (acc_done_i),
    .acc_start_o (acc_start_o),
    .capt_o      (capt),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .irq_o       (irq_o)
  );

  logic [DATA_WIDTH-1:0] bank_a_q [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] bank_a_d [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] bank_b_q [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] bank_b_d [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] res_q    [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] res_d    [ACC_DEPTH];
  logic                  bank_we;

  assign bank_we = en_i & we_i & ~busy;

  always_comb begin
    bank_a_d = bank_a_q;
    bank_b_d = bank_b_q;
    res_d    = res_q;
    for (int i = 0; i < BE_W; i++) begin
      if (bank_we && be_i[i]) begin
        if (sel_dec == SEL_A) bank_a_d[idx_dec][i*8 +: 8] = wdata_i[i*8 +: 8];
        if (sel_dec == SEL_B) bank_b_d[idx_dec][i*8 +: 8] = wdata_i[i*8 +: 8];
      end
    end
    if (capt) begin
      for (int k = 0; k < ACC_DEPTH; k++) res_d[k] = acc_res_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      bank_a_q <= '{default: '0};
      bank_b_q <= '{default: '0};
      res_q    <= '{default: '0};
    end else begin
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
      res_q    <= res_d;
    end
  end

  for (genvar k = 0; k < ACC_DEPTH; k++) begin : g_flat
    assign acc_a_o[k*DATA_WIDTH +: DATA_WIDTH] = bank_a_q[k];
    assign acc_b_o[k*DATA_WIDTH +: DATA_WIDTH] = bank_b_q[k];
  end

  logic [DATA_WIDTH-1:0] ram_dout;

  sp_ram_acc_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW),
    .DW    (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .en_i   (en_i & ~in_win),
    .wea_i  (be_i & {BE_W{we_i}}),
    .addr_i (addr_i[BOFF_W +: RAM_AW]),
    .din_i  (wdata_i),
    .dout_o (ram_dout)
  );

  acc_sel_e              sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] ctrl_word, rd_mux;

  // hold_q shadows rdata_o so the output stays put across idle cycles even if a bank changes.
  always_comb begin
    sel_d    = sel_q;
    idx_d    = idx_q;
    rd_vld_d = en_i;
    if (en_i) begin
      sel_d = sel_dec;
      idx_d = idx_dec;
    end
    ctrl_word                = '0;
    ctrl_word[CTRL_BUSY_BIT] = busy;
    ctrl_word[CTRL_DONE_BIT] = done;
    ctrl_word[CTRL_ERR_BIT]  = err;
    case (sel_q)
      SEL_RAM:  rd_mux = ram_dout;
      SEL_A:    rd_mux = bank_a_q[idx_q];
      SEL_B:    rd_mux = bank_b_q[idx_q];
      SEL_RES:  rd_mux = res_q[idx_q];
      SEL_CTRL: rd_mux = ctrl_word;
      default:  rd_mux = '0;
    endcase
    rdata_o = rd_vld_q ? rd_mux : hold_q;
    hold_d  = rdata_o;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sel_q    <= SEL_NONE;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      rd_vld_q <= rd_vld_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_sp_ram_acc_wrap.sv
// Randomised scoreboard bench for sp_ram_acc_wrap against a byte-level window/RAM reference model.
module tb_sp_ram_acc_wrap;

  localparam int RAM_SIZE = 32768;
  localparam int AW       = 15;
  localparam int DW       = 32;
  localparam int BASE     = 'h7000;
  localparam int DEPTH    = 16;
  localparam int TO       = 8;
  localparam int W        = 4 * DEPTH;
  localparam int CTRL_A   = BASE + 3 * W;

  logic                  clk = 1'b0;
  logic                  rst_i, en_i, we_i, acc_done_i;
  logic [AW-1:0]         addr_i;
  logic [DW-1:0]         wdata_i, rdata_o;
  logic [3:0]            be_i;
  logic [DEPTH*DW-1:0]   acc_a_o, acc_b_o, acc_res_i;
  logic                  acc_start_o, irq_o;

  sp_ram_acc_wrap #(
    .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ACC_BASE(BASE), .ACC_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .be_i(be_i), .rdata_o(rdata_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o),
    .acc_res_i(acc_res_i), .acc_start_o(acc_start_o), .acc_done_i(acc_done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  logic [DW-1:0] ram_m [int];
  logic [DW-1:0] a_m [DEPTH];
  logic [DW-1:0] b_m [DEPTH];
  logic [DW-1:0] res_m [DEPTH];
  bit            busy_m, done_m, err_m;
  logic [DW-1:0] exp_q [$];
  logic          rd_pend = 1'b0;
  int            pool [8];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ctrl_val();
    return DW'({err_m, done_m, busy_m, 1'b0});
  endfunction

  function automatic logic [DW-1:0] model_read(input int addr);
    int off;
    off = addr - BASE;
    if (addr < BASE || off >= 4 * W) return ram_m.exists(addr / 4) ? ram_m[addr / 4] : 'x;
    case (off / W)
      0: return a_m[(off % W) / 4];
      1: return b_m[(off % W) / 4];
      2: return res_m[(off % W) / 4];
      default: return (off == 3 * W) ? ctrl_val() : '0;
    endcase
  endfunction

  task automatic model_write(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
    int off;
    off = addr - BASE;
    if (addr < BASE || off >= 4 * W) begin
      ram_m[addr / 4] = merge(ram_m.exists(addr / 4) ? ram_m[addr / 4] : '0, d, be);
    end else if (off / W == 0) begin
      if (!busy_m) a_m[(off % W) / 4] = merge(a_m[(off % W) / 4], d, be);
    end else if (off / W == 1) begin
      if (!busy_m) b_m[(off % W) / 4] = merge(b_m[(off % W) / 4], d, be);
    end else if (off == 3 * W && be[0]) begin
      if (d[2]) done_m = 1'b0;
      if (d[3]) err_m = 1'b0;
      if (d[0] && !busy_m) busy_m = 1'b1;
    end
  endtask

  task automatic model_reset();
    busy_m = 0; done_m = 0; err_m = 0;
    for (int k = 0; k < DEPTH; k++) begin a_m[k] = '0; b_m[k] = '0; res_m[k] = '0; end
  endtask

  task automatic issue(input int addr, input bit we, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clk);
    en_i = 1'b1; we_i = we; addr_i = AW'(addr); wdata_i = d; be_i = be;
    if (we) model_write(addr, d, be);
    else    exp_q.push_back(model_read(addr));
    @(posedge clk);
    #1;
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic check_banks(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      check({tag, "_a"}, acc_a_o[k*DW +: DW], a_m[k]);
      check({tag, "_b"}, acc_b_o[k*DW +: DW], b_m[k]);
    end
  endtask

  always @(posedge clk) rd_pend <= en_i && !we_i && !rst_i;

  always @(negedge clk) begin
    if (acc_start_o === 1'b1) start_cnt++;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected: got %h expected no read", rdata_o);
      end else begin
        check("rdata", rdata_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1; en_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    acc_res_i = '0; acc_done_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata_o, '0);
    check("rst_irq", DW'(irq_o), '0);
    check("rst_start", DW'(acc_start_o), '0);
    check("rst_acc_a", DW'(|acc_a_o), '0);
    check("rst_acc_b", DW'(|acc_b_o), '0);
    rst_i = 0;

    pool = '{'h0010, BASE - 4, BASE + 4 * W, 'h0000, 'h7ffc, 'h1234, BASE + 4 * W + 'h40, BASE - 'h100};
    foreach (pool[i]) issue(pool[i], 1, $urandom, 4'hF);

    issue('h0010, 1, 32'hDEADBEEF, 4'hF);
    issue('h0010, 0, '0, 4'h0);
    issue(BASE + 'h0C, 1, 32'h11223344, 4'b0101);
    @(negedge clk);
    check("be_word3", acc_a_o[3*DW +: DW], 32'h00220044);
    issue(BASE + 'h0C, 0, '0, 4'h0);
    issue(BASE - 4, 1, 32'hA5A5_0001, 4'hF);
    issue(BASE + 4 * W, 1, 32'h5A5A_0002, 4'hF);
    issue(BASE - 4, 0, '0, 4'h0);
    issue(BASE + 4 * W, 0, '0, 4'h0);
    issue(CTRL_A + 4, 1, 32'hFFFF_FFFF, 4'hF);
    issue(CTRL_A + 4, 0, '0, 4'h0);
    @(negedge clk);
    check_banks("boundary");

    for (int n = 0; n < 300; n++) begin
      int r, addr;
      bit we;
      r = int'($urandom_range(0, 4));
      we = 1'($urandom);
      case (r)
        0: addr = pool[$urandom_range(0, 7)];
        1: addr = BASE + 4 * int'($urandom_range(0, DEPTH - 1));
        2: addr = BASE + W + 4 * int'($urandom_range(0, DEPTH - 1));
        3: addr = BASE + 2 * W + 4 * int'($urandom_range(0, DEPTH - 1));
        default: addr = CTRL_A + 4 * int'($urandom_range(0, DEPTH - 1));
      endcase
      if (addr == CTRL_A) we = 1'b0;
      issue(addr, we, $urandom, 4'($urandom));
    end
    @(negedge clk);
    check_banks("random");

    // Full accelerator run with done 7 cycles after start.
    for (int k = 0; k < DEPTH; k++) begin
      issue(BASE + 4 * k, 1, $urandom, 4'hF);
      issue(BASE + W + 4 * k, 1, $urandom, 4'hF);
      acc_res_i[k*DW +: DW] = DW'(k + 5);
    end
    issue(CTRL_A, 1, 32'h1, 4'hF);
    @(negedge clk);
    check("start_pulse", DW'(acc_start_o), 1);
    issue(CTRL_A, 0, '0, 4'h0);
    issue(BASE + W, 1, 32'hFFFF_FFFF, 4'hF);
    issue(CTRL_A, 1, 32'h1, 4'hF);
    issue(BASE + W, 0, '0, 4'h0);
    issue(BASE + 4 * 5, 0, '0, 4'h0);
    @(negedge clk) acc_done_i = 1;
    @(negedge clk) acc_done_i = 0;
    repeat (2) @(negedge clk);
    busy_m = 0; done_m = 1;
    for (int k = 0; k < DEPTH; k++) res_m[k] = DW'(k + 5);
    check("irq_after_run", DW'(irq_o), 1);
    check("start_once", DW'(start_cnt), 1);
    for (int k = 0; k < DEPTH; k++) issue(BASE + 2 * W + 4 * k, 0, '0, 4'h0);
    issue(CTRL_A, 0, '0, 4'h0);
    check_banks("run");
    issue(CTRL_A, 1, 32'h4, 4'hF);
    @(negedge clk);
    check("irq_cleared", DW'(irq_o), 0);
    issue(CTRL_A, 0, '0, 4'h0);

    // acc_done_i while idle must not capture or set done.
    for (int k = 0; k < DEPTH; k++) acc_res_i[k*DW +: DW] = DW'(k + 100);
    @(negedge clk) acc_done_i = 1;
    @(negedge clk) acc_done_i = 0;
    repeat (2) @(negedge clk);
    check("idle_done_irq", DW'(irq_o), 0);
    issue(CTRL_A, 0, '0, 4'h0);
    issue(BASE + 2 * W + 4, 0, '0, 4'h0);

    // Done sampled in the same cycle as the start pulse.
    issue(CTRL_A, 1, 32'h1, 4'hF);
    acc_done_i = 1;
    @(negedge clk);
    check("start_pulse2", DW'(acc_start_o), 1);
    @(posedge clk);
    #1 acc_done_i = 0;
    repeat (3) @(negedge clk);
    busy_m = 0; done_m = 1;
    for (int k = 0; k < DEPTH; k++) res_m[k] = DW'(k + 100);
    check("irq_fast_done", DW'(irq_o), 1);
    check("start_twice", DW'(start_cnt), 2);
    issue(BASE + 2 * W + 12, 0, '0, 4'h0);
    issue(CTRL_A, 0, '0, 4'h0);
    issue(CTRL_A, 1, 32'h4, 4'hF);

`ifdef ACC_TIMEOUT_EN
    issue(CTRL_A, 1, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    issue(CTRL_A, 0, '0, 4'h0);
    repeat (10) @(negedge clk);
    busy_m = 0; err_m = 1;
    check("timeout_irq", DW'(irq_o), 1);
    issue(CTRL_A, 0, '0, 4'h0);
    issue(BASE + 2 * W, 0, '0, 4'h0);
    issue(CTRL_A, 1, 32'h8, 4'hF);
    issue(CTRL_A, 0, '0, 4'h0);
`endif

    // Reset in the middle of a run aborts without capture.
    for (int k = 0; k < DEPTH; k++) acc_res_i[k*DW +: DW] = DW'(k + 200);
    issue(CTRL_A, 1, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    check("midrst_rdata", rdata_o, '0);
    check("midrst_irq", DW'(irq_o), '0);
    check("midrst_start", DW'(acc_start_o), '0);
    check("midrst_acc_a", DW'(|acc_a_o), '0);
    check("midrst_acc_b", DW'(|acc_b_o), '0);
    rst_i = 0;
    model_reset();
    acc_done_i = 1;
    @(negedge clk) acc_done_i = 0;
    repeat (2) @(negedge clk);
    issue(CTRL_A, 0, '0, 4'h0);
    issue(BASE + 2 * W + 8, 0, '0, 4'h0);
    issue(BASE + 16, 0, '0, 4'h0);
    issue('h0010, 0, '0, 4'h0);

    repeat (3) @(negedge clk);
    check("sb_drained", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
